// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter onto a shared peripheral bus with window
// decode, per-transaction timeout and a registered one-cycle response pulse.
module periph_bus_arbiter #(
  parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
  parameter int          SLAVE_SHIFT     = 12,
  parameter int          NUM_SLAVES      = 4,
  parameter int          TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m0_valid,
  input  logic [63:0]                m0_addr,
  input  logic                       m0_write,
  input  logic [63:0]                m0_wdata,
  output logic                       m0_ready,
  output logic [63:0]                m0_rdata,
  output logic                       m0_err,
  input  logic                       m1_valid,
  input  logic [63:0]                m1_addr,
  input  logic                       m1_write,
  input  logic [63:0]                m1_wdata,
  output logic                       m1_ready,
  output logic [63:0]                m1_rdata,
  output logic                       m1_err,
  output logic [NUM_SLAVES-1:0]      s_sel,
  output logic [63:0]                s_addr,
  output logic                       s_write,
  output logic [63:0]                s_wdata,
  input  logic [NUM_SLAVES*64-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [63:0] OFF_MASK = (64'd1 << SLAVE_SHIFT) - 64'd1;
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  state_t                  state_r, state_s;
  logic                    gnt_r, gnt_s;
  logic                    last_grant_r, last_grant_s;
  logic [7:0]              cnt_r, cnt_s;
  logic [NUM_SLAVES-1:0]   sel_s;
  logic [63:0]             addr_s, wdata_s;
  logic                    write_s;

  logic                    pick_s, req_write_s, dec_err_s;
  logic [63:0]             req_addr_s, req_wdata_s, off_s, idx_s;
  logic [NUM_SLAVES-1:0]   dec_sel_s;
  logic                    hit_s;
  logic [63:0]             rd_slice_s;

  logic                    rsp_en_s, rsp_err_s;
  logic [63:0]             rsp_rdata_s;
  logic                    m0_ready_s, m0_err_s, m1_ready_s, m1_err_s;
  logic [63:0]             m0_rdata_s, m1_rdata_s;

  // Round-robin pick between requesters and window decode of the winner
  always_comb begin
    pick_s = 1'b0;
    if (m0_valid && m1_valid) begin
      pick_s = ~last_grant_r;
    end else if (m1_valid) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    req_addr_s  = pick_s ? m1_addr  : m0_addr;
    req_write_s = pick_s ? m1_write : m0_write;
    req_wdata_s = pick_s ? m1_wdata : m0_wdata;
    off_s       = req_addr_s - PERIPHERAL_BASE;
    idx_s       = off_s >> SLAVE_SHIFT;
    dec_err_s   = (req_addr_s < PERIPHERAL_BASE) || (idx_s >= 64'(NUM_SLAVES));
    dec_sel_s   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_sel_s[i] = (idx_s == 64'(i));
    end
  end

  // Only the selected slave's ready and read data are observed
  always_comb begin
    hit_s      = |(s_ready & s_sel);
    rd_slice_s = 64'd0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rd_slice_s = rd_slice_s | (s_rdata[i*64 +: 64] & {64{s_sel[i]}});
    end
  end

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_s      = state_r;
    gnt_s        = gnt_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    sel_s        = s_sel;
    addr_s       = s_addr;
    write_s      = s_write;
    wdata_s      = s_wdata;
    rsp_en_s     = 1'b0;
    rsp_err_s    = 1'b0;
    rsp_rdata_s  = 64'd0;
    case (state_r)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          gnt_s = pick_s;
          cnt_s = 8'd0;
          if (dec_err_s) begin
            state_s = ERR;
          end else begin
            state_s = BUSY;
            sel_s   = dec_sel_s;
            addr_s  = off_s & OFF_MASK;
            write_s = req_write_s;
            wdata_s = req_wdata_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // A ready landing in the final timeout cycle still wins
        if (hit_s) begin
          sel_s       = '0;
          rsp_en_s    = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_rdata_s = s_write ? 64'd0 : rd_slice_s;
          state_s     = RESP;
        end else if (cnt_r == TMO_LAST) begin
          sel_s     = '0;
          rsp_en_s  = 1'b1;
          rsp_err_s = 1'b1;
          state_s   = RESP;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ERR: begin
        rsp_en_s  = 1'b1;
        rsp_err_s = 1'b1;
        state_s   = RESP;
      end
      RESP: begin
        last_grant_s = gnt_r;
        cnt_s        = 8'd0;
        state_s      = IDLE;
      end
      default: begin
        sel_s   = '0;
        cnt_s   = 8'd0;
        state_s = IDLE;
      end
    endcase
  end

  // Route the response to the granted master; both stay zero otherwise
  always_comb begin
    m0_ready_s = 1'b0;
    m0_err_s   = 1'b0;
    m0_rdata_s = 64'd0;
    m1_ready_s = 1'b0;
    m1_err_s   = 1'b0;
    m1_rdata_s = 64'd0;
    if (rsp_en_s && gnt_r) begin
      m1_ready_s = 1'b1;
      m1_err_s   = rsp_err_s;
      m1_rdata_s = rsp_rdata_s;
    end else if (rsp_en_s) begin
      m0_ready_s = 1'b1;
      m0_err_s   = rsp_err_s;
      m0_rdata_s = rsp_rdata_s;
    end else begin
      m0_ready_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant bookkeeping, timeout counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r        <= 1'b0;
      last_grant_r <= 1'b1;
      cnt_r        <= 8'd0;
      s_sel        <= '0;
      s_addr       <= 64'd0;
      s_write      <= 1'b0;
      s_wdata      <= 64'd0;
      m0_ready     <= 1'b0;
      m0_rdata     <= 64'd0;
      m0_err       <= 1'b0;
      m1_ready     <= 1'b0;
      m1_rdata     <= 64'd0;
      m1_err       <= 1'b0;
    end else begin
      gnt_r        <= gnt_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
      s_sel        <= sel_s;
      s_addr       <= addr_s;
      s_write      <= write_s;
      s_wdata      <= wdata_s;
      m0_ready     <= m0_ready_s;
      m0_rdata     <= m0_rdata_s;
      m0_err       <= m0_err_s;
      m1_ready     <= m1_ready_s;
      m1_rdata     <= m1_rdata_s;
      m1_err       <= m1_err_s;
    end
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed vector table, multi-cycle corner
// sequences and randomized two-master traffic against a transaction model.
module tb_periph_bus_arbiter;

  localparam logic [63:0] BASE = 64'h2000_0000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         m0_valid, m0_write, m0_ready, m0_err;
  logic [63:0]  m0_addr, m0_wdata, m0_rdata;
  logic         m1_valid, m1_write, m1_ready, m1_err;
  logic [63:0]  m1_addr, m1_wdata, m1_rdata;
  logic [3:0]   s_sel, s_ready;
  logic [63:0]  s_addr, s_wdata;
  logic         s_write;
  logic [255:0] s_rdata;

  periph_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_sel(s_sel), .s_addr(s_addr), .s_write(s_write), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
  } txn_t;

  typedef struct {
    int          m;
    logic [63:0] addr;
    logic        write;
    logic [63:0] wdata;
    int          lat;
    bit          drop;
    logic [3:0]  sel;
    logic [63:0] saddr;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] rd_word [4];
  int          sel_cnt = 0;
  int          slave_lat = 1;
  bit          rand_lat = 1'b0, noise_en = 1'b0, mix_en = 1'b0, gap_en = 1'b0;
  logic [3:0]  extra = 4'd0;
  txn_t        q0[$], q1[$];
  int          order[$];
  int          prev_resp = -1;
  bit          both_cont = 1'b1;
  vec_t        vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: decode by division, data from the slave model
  function automatic void model(input txn_t t, output logic err, output logic [63:0] rd,
                                output logic [3:0] sel, output logic [63:0] off);
    logic [63:0] d;
    int idx;
    err = 1'b0; rd = 64'd0; sel = 4'd0; off = 64'd0;
    if (t.addr < BASE) begin
      err = 1'b1;
    end else begin
      d = t.addr - BASE;
      if (d >= 64'd16384) begin
        err = 1'b1;
      end else begin
        idx = int'(d / 64'd4096);
        off = d % 64'd4096;
        sel = 4'(1 << idx);
        rd  = t.write ? 64'd0 : (rd_word[idx] ^ (mix_en ? off : 64'd0));
      end
    end
  endfunction

  function automatic logic consistent(input txn_t t);
    logic e; logic [63:0] rd, off; logic [3:0] sel;
    model(t, e, rd, sel, off);
    return !e && (s_sel == sel) && (s_addr == off) && (s_write == t.write) &&
           (!t.write || (s_wdata == t.wdata));
  endfunction

  function automatic txn_t gen();
    txn_t t;
    int k;
    k = $urandom_range(0, 19);
    if (k < 14) begin
      t.addr = BASE + 64'($urandom_range(0, 3)) * 64'd4096 + 64'($urandom_range(0, 511)) * 64'd8;
    end else if (k < 17) begin
      t.addr = BASE + 64'($urandom_range(4, 15)) * 64'd4096 + 64'($urandom_range(0, 4095));
    end else begin
      t.addr = BASE - 64'($urandom_range(1, 65536));
    end
    t.write = 1'($urandom_range(0, 1));
    t.wdata = {$urandom, $urandom};
    return t;
  endfunction

  // One clock; then the slave model reacts to the freshly registered select
  task automatic step();
    logic [3:0] rdy;
    @(posedge clk);
    #1;
    if (|s_sel) sel_cnt++;
    else sel_cnt = 0;
    if (sel_cnt == 1 && rand_lat) slave_lat = $urandom_range(1, 4);
    rdy = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (s_sel[i] && slave_lat != 0 && sel_cnt >= slave_lat) rdy[i] = 1'b1;
    end
    if (noise_en) rdy = rdy | (4'($urandom) & ~s_sel);
    s_ready = rdy | (extra & ~s_sel);
    for (int i = 0; i < 4; i++) begin
      s_rdata[i*64 +: 64] = rd_word[i] ^ (mix_en ? s_addr : 64'd0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic got, e_act;
    logic [63:0] rd_act;
    int cyc, sel_hi;
    if (v.m == 0) begin
      m0_addr = v.addr; m0_write = v.write; m0_wdata = v.wdata; m0_valid = 1'b1;
    end else begin
      m1_addr = v.addr; m1_write = v.write; m1_wdata = v.wdata; m1_valid = 1'b1;
    end
    slave_lat = v.lat;
    cyc = 0; got = 1'b0; sel_hi = 0;
    while (!got && cyc < 400) begin
      step();
      cyc++;
      if (|s_sel) sel_hi++;
      if (cyc == 1) begin
        if (v.drop) begin
          m0_valid = 1'b0; m1_valid = 1'b0;
        end
        chk("vec_sel", 64'(s_sel), 64'(v.sel));
        if (v.sel != 4'd0) begin
          chk("vec_saddr", s_addr, v.saddr);
          chk("vec_swrite", 64'(s_write), 64'(v.write));
          chk("vec_swdata", s_wdata, v.wdata);
        end
      end
      got = (v.m == 0) ? m0_ready : m1_ready;
    end
    rd_act = (v.m == 0) ? m0_rdata : m1_rdata;
    e_act  = (v.m == 0) ? m0_err : m1_err;
    chk("vec_ready", 64'(got), 64'd1);
    chk("vec_latency", 64'(cyc), 64'(v.cyc));
    chk("vec_sel_cycles", 64'(sel_hi), (v.sel == 4'd0) ? 64'd0 : 64'(v.cyc - 1));
    chk("vec_rdata", rd_act, v.rdata);
    chk("vec_err", 64'(e_act), 64'(v.err));
    chk("vec_other_quiet", 64'((v.m == 0) ? m1_ready : m0_ready), 64'd0);
    m0_valid = 1'b0; m1_valid = 1'b0;
    step();
  endtask

  task automatic handle(input int m);
    txn_t t;
    logic e; logic [63:0] rd, off; logic [3:0] sel;
    chk("resp_pending", 64'(((m == 0) ? q0.size() : q1.size()) > 0), 64'd1);
    if (((m == 0) ? q0.size() : q1.size()) > 0) begin
      t = (m == 0) ? q0.pop_front() : q1.pop_front();
      model(t, e, rd, sel, off);
      chk("resp_rdata", (m == 0) ? m0_rdata : m1_rdata, rd);
      chk("resp_err", 64'((m == 0) ? m0_err : m1_err), 64'(e));
      if (prev_resp >= 0 && both_cont) chk("round_robin", 64'(m), 64'(1 - prev_resp));
      order.push_back(m);
      prev_resp = m;
      both_cont = 1'b1;
    end
    if (m == 0) m0_valid = 1'b0;
    else m1_valid = 1'b0;
  endtask

  task automatic rand_step();
    logic r0, r1, ok;
    step();
    r0 = m0_ready; r1 = m1_ready;
    if (r0 || r1) chk("one_ready", 64'(r0 && r1), 64'd0);
    if (sel_cnt == 1) begin
      ok = 1'b0;
      if (m0_valid && q0.size() > 0) ok = ok | consistent(q0[0]);
      if (m1_valid && q1.size() > 0) ok = ok | consistent(q1[0]);
      chk("sel_match", 64'(ok), 64'd1);
    end
    if (r0) handle(0);
    if (r1) handle(1);
    if (!m0_valid && q0.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      m0_addr = q0[0].addr; m0_write = q0[0].write; m0_wdata = q0[0].wdata; m0_valid = 1'b1;
    end
    if (!m1_valid && q1.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
      m1_addr = q1[0].addr; m1_write = q1[0].write; m1_wdata = q1[0].wdata; m1_valid = 1'b1;
    end
    both_cont = both_cont && m0_valid && m1_valid;
  endtask

  task automatic run_queues(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      rand_step();
      n++;
    end
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
    m0_valid = 1'b0; m1_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got, any_rdy;
    txn_t t;
    rd_word[0] = 64'h1111_0000_0000_0A0A;
    rd_word[1] = 64'h0000_0000_0000_CAFE;
    rd_word[2] = 64'h2222_BEEF_0000_0002;
    rd_word[3] = 64'h3333_0000_DEAD_0003;
    vecs[0]  = '{0, 64'h2000_1008, 1'b0, 64'h0, 1, 1'b0, 4'b0010, 64'h8, 64'hCAFE, 1'b0, 2};
    vecs[1]  = '{1, 64'h2000_5000, 1'b1, 64'h55AA, 1, 1'b0, 4'b0000, 64'h0, 64'h0, 1'b1, 2};
    vecs[2]  = '{1, 64'h1000_0000, 1'b0, 64'h0, 1, 1'b0, 4'b0000, 64'h0, 64'h0, 1'b1, 2};
    vecs[3]  = '{0, 64'h2000_2000, 1'b0, 64'h0, 0, 1'b0, 4'b0100, 64'h0, 64'h0, 1'b1, 256};
    vecs[4]  = '{1, 64'h2000_3FF8, 1'b0, 64'h0, 3, 1'b0, 4'b1000, 64'hFF8, 64'h3333_0000_DEAD_0003, 1'b0, 4};
    vecs[5]  = '{0, 64'h2000_0000, 1'b1, 64'hDEAD_BEEF_0123_4567, 2, 1'b0, 4'b0001, 64'h0, 64'h0, 1'b0, 3};
    vecs[6]  = '{1, 64'h1FFF_FFFF, 1'b0, 64'h0, 1, 1'b0, 4'b0000, 64'h0, 64'h0, 1'b1, 2};
    vecs[7]  = '{0, 64'h2000_4000, 1'b0, 64'h0, 1, 1'b0, 4'b0000, 64'h0, 64'h0, 1'b1, 2};
    vecs[8]  = '{0, 64'h2000_2010, 1'b0, 64'h0, 255, 1'b0, 4'b0100, 64'h10, 64'h2222_BEEF_0000_0002, 1'b0, 256};
    vecs[9]  = '{1, 64'h2000_0100, 1'b0, 64'h0, 1, 1'b1, 4'b0001, 64'h100, 64'h1111_0000_0000_0A0A, 1'b0, 2};
    vecs[10] = '{0, 64'h2000_1FFF, 1'b1, 64'h0F0F, 1, 1'b0, 4'b0010, 64'hFFF, 64'h0, 1'b0, 2};
    vecs[11] = '{1, 64'hFFFF_FFFF_0000_0000, 1'b1, 64'h1, 1, 1'b0, 4'b0000, 64'h0, 64'h0, 1'b1, 2};

    rst_n = 1'b0;
    m0_valid = 1'b0; m0_addr = 64'd0; m0_write = 1'b0; m0_wdata = 64'd0;
    m1_valid = 1'b0; m1_addr = 64'd0; m1_write = 1'b0; m1_wdata = 64'd0;
    s_ready = 4'd0; s_rdata = 256'd0;
    #12;
    chk("reset_ctrl", 64'({s_sel, m0_ready, m1_ready, m0_err, m1_err, s_write}), 64'd0);
    chk("reset_data", s_addr | s_wdata | m0_rdata | m1_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Unselected slave's ready must not complete the access
    extra = 4'b1000; slave_lat = 0; any_rdy = 1'b0;
    m0_addr = 64'h2000_0020; m0_write = 1'b0; m0_wdata = 64'd0; m0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) chk("stray_sel", 64'(s_sel), 64'h1);
      any_rdy = any_rdy | m0_ready | m1_ready;
    end
    chk("stray_ready_ignored", 64'(any_rdy), 64'd0);
    extra = 4'd0; slave_lat = 1; got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step();
      got = m0_ready;
    end
    chk("stray_then_ready", 64'(got), 64'd1);
    chk("stray_rdata", m0_rdata, 64'h1111_0000_0000_0A0A);
    chk("stray_err", 64'(m0_err), 64'd0);
    m0_valid = 1'b0;
    step();

    // Asynchronous reset while a slave is stuck in BUSY
    slave_lat = 0;
    m0_addr = 64'h2000_2040; m0_write = 1'b0; m0_valid = 1'b1;
    step(); step(); step();
    chk("pre_reset_busy", 64'(s_sel), 64'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", 64'({s_sel, m0_ready, m1_ready, m0_err, m1_err, s_write}), 64'd0);
    chk("midreset_data", s_addr | s_wdata | m0_rdata | m1_rdata, 64'd0);
    m0_valid = 1'b0; s_ready = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Both masters requesting from reset: strict alternation starting at m0
    slave_lat = 2; rand_lat = 1'b0; gap_en = 1'b0; noise_en = 1'b0; mix_en = 1'b0;
    prev_resp = -1; both_cont = 1'b1; order.delete();
    t = '{64'h2000_0008, 1'b0, 64'h0};        q0.push_back(t);
    t = '{64'h2000_2010, 1'b0, 64'h0};        q0.push_back(t);
    t = '{64'h2000_1100, 1'b0, 64'h0};        q1.push_back(t);
    t = '{64'h2000_3000, 1'b1, 64'hABCD};     q1.push_back(t);
    run_queues(100);
    chk("alt_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < order.size(); i++) chk("alt_order", 64'(order[i]), 64'(i % 2));

    // Randomized traffic with gaps, spurious readies and address-dependent data
    rand_lat = 1'b1; gap_en = 1'b1; noise_en = 1'b1; mix_en = 1'b1;
    prev_resp = -1; both_cont = 1'b1;
    for (int i = 0; i < 60; i++) begin
      q0.push_back(gen());
      q1.push_back(gen());
    end
    run_queues(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Arbitrates two data masters onto one shared peripheral bus and decodes the address to one of NUM_SLAVES peripheral windows above PERIPHERAL_BASE.
- Master 0 is the core data port. Its m0_valid is the hazard unit's d_valid, and m0_ready feeds its d_ready, so the core stalls until completion.
- Master 1 is the DMA/debug port.
- The block sequences each transaction: grant, select, wait, respond. It enforces a timeout so a dead slave cannot hang the pipeline.

Parameters:
- PERIPHERAL_BASE, 64'h2000_0000, start of the peripheral address space.
- SLAVE_SHIFT, 12, log2 of the window size per slave (4 KiB).
- NUM_SLAVES, 4, number of slave windows (1..8).
- TIMEOUT, 255, number of BUSY cycles without s_ready before an error response (1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- m0_valid / m1_valid  in  1  request; held high and stable until that master's ready pulse
- m0_addr / m1_addr  in  64  byte address
- m0_write / m1_write  in  1  1 = store, 0 = load
- m0_wdata / m1_wdata  in  64  store data
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  64  load data, valid only with ready
- m0_err / m1_err  out  1  decode or timeout error, valid only with ready
- s_sel  out  NUM_SLAVES  one-hot slave select, registered
- s_addr  out  64  address offset inside the window, registered
- s_write  out  1  registered
- s_wdata  out  64  registered
- s_rdata  in  NUM_SLAVES*64  slave i drives bits [64i+63:64i]
- s_ready  in  NUM_SLAVES  slave i completes the access

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE.
  - All outputs go to 0 immediately, including the ready, err, rdata, s_sel, s_addr, s_write and s_wdata outputs.
  - Timeout counter = 0; last_grant = 1, so master 0 wins the first tie.
  - A transaction aborted by reset gives no response, and masters must re-request.
- FSM states: IDLE, BUSY, ERR, RESP.
- IDLE:
  - If exactly one valid is high, grant that master.
  - If both are high, grant the master that is not last_grant (round-robin).
  - Latch the granted addr, write and wdata.
  - idx = (addr - PERIPHERAL_BASE) >> SLAVE_SHIFT.
  - If addr < PERIPHERAL_BASE or idx >= NUM_SLAVES, go to ERR.
  - Otherwise go to BUSY with s_sel[idx] = 1 and s_addr = addr - PERIPHERAL_BASE - (idx << SLAVE_SHIFT).
- BUSY:
  - s_sel stays stable. The counter increments each cycle.
  - Only s_ready[idx] is observed; s_ready of unselected slaves is ignored.
  - When s_ready[idx] = 1: capture the s_rdata slice (zero for writes), clear s_sel, set err = 0, go to RESP.
  - When the counter reaches TIMEOUT before s_ready: clear s_sel, set rdata = 0 and err = 1, go to RESP. A ready arriving in that same cycle wins over the timeout.
- ERR: one cycle, no slave access. rdata = 0, err = 1, go to RESP.
- RESP:
  - The granted master's ready pulses for exactly one cycle with its rdata and err. The other master's outputs stay 0.
  - Update last_grant, clear the counter, go to IDLE.
- Latency: valid seen in cycle 0 → s_sel high in cycle 1. With s_ready in cycle 1, ready is in cycle 2. A decode error gives ready in cycle 2.
- Throughput: minimum 3 cycles per transaction.
- A master's valid dropping mid-transaction is ignored: the transaction completes and ready still pulses.
- Valid high in the cycle after ready is treated as a new request.
- The non-granted master waits; its valid is held and it is considered at the next IDLE, so there is no starvation.

Test Plan:
- m0 loads from 0x2000_1008, slave 1 raises s_ready in the first BUSY cycle with rdata 0xCAFE: s_sel = 0b0010 and s_addr = 0x8 in cycle 1; m0_ready = 1 with m0_rdata = 0xCAFE and m0_err = 0 in cycle 2.
- m0 and m1 both valid from reset, each slave takes 2 cycles: grant order m0, m1, m0, m1; the ready pulses alternate and are never simultaneous.
- m1 writes 0x2000_5000 (idx 5 ≥ 4): no s_sel activity; m1_ready = 1 with m1_err = 1 in cycle 2. An address of 0x1000_0000 gives the same response.
- Slave 2 never asserts s_ready, TIMEOUT = 255: s_sel[2] stays high for 255 cycles, then m0_ready = 1 with m0_err = 1 and m0_rdata = 0.
- rst_n asserted low while in BUSY: s_sel and all ready outputs drop in the same cycle. After release, a new m0 request completes normally and m0 wins the first tie.
- s_ready[3] asserted while slave 0 is selected: ignored, no response until s_ready[0] is asserted.
